comparator_2bit_behavioral_design: RTL and testbench

//   2-bit unsigned magnitude comparator on operands A = {A1,A0} and B = {B1,B0}.

---
 rtl/comparator_2bit_behavioral_design.sv | 77 +++++++
 tb/tb_comparator_2bit_behavioral_design.sv | 120 ++++++++++++
 2 files changed

// File: rtl/comparator_2bit_behavioral_design.sv
// 2-bit unsigned magnitude comparator with one-hot greater/equal/less flags.
// Define CMP2_OUT_REG_EN to register the flags (1-cycle latency, sync reset to the equal state).
module comparator_2bit_behavioral_design (
   input  logic clk,
   input  logic rst,
   input  logic A0,
   input  logic A1,
   input  logic B0,
   input  logic B1,
   output logic AgtB,
   output logic AeqB,
   output logic AltB
);

   localparam int unsigned OPW = 2;

   logic [OPW-1:0] op_a;
   logic [OPW-1:0] op_b;
   logic           gt_c;
   logic           eq_c;
   logic           lt_c;

   assign op_a = {A1, A0};
   assign op_b = {B1, B0};

   // MSB decides unless equal, then LSB decides; all-equal falls through to eq.
   always_comb begin
      gt_c = 1'b0;
      eq_c = 1'b0;
      lt_c = 1'b0;
      if (op_a[1] != op_b[1]) begin
         gt_c = op_a[1];
         lt_c = op_b[1];
      end else if (op_a[0] != op_b[0]) begin
         gt_c = op_a[0];
         lt_c = op_b[0];
      end else begin
         eq_c = 1'b1;
      end
   end

`ifdef CMP2_OUT_REG_EN
   logic gt_d, eq_d, lt_d;
   logic gt_q, eq_q, lt_q;

   // Reset wins over a fresh compare result and parks the flags in the equal state.
   always_comb begin
      gt_d = gt_c;
      eq_d = eq_c;
      lt_d = lt_c;
      if (rst) begin
         gt_d = 1'b0;
         eq_d = 1'b1;
         lt_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      gt_q <= gt_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
   end

   assign AgtB = gt_q;
   assign AeqB = eq_q;
   assign AltB = lt_q;
`else
   // Clock and reset have no function in the combinational build.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   assign AgtB = gt_c;
   assign AeqB = eq_c;
   assign AltB = lt_c;
`endif

endmodule

// File: tb/tb_comparator_2bit_behavioral_design.sv
// Self-checking bench for comparator_2bit_behavioral_design; follows CMP2_OUT_REG_EN
// to choose between combinational and registered expectations.
module tb_comparator_2bit_behavioral_design;

   logic clk = 1'b0;
   logic rst;
   logic A0, A1, B0, B1;
   logic AgtB, AeqB, AltB;

   int checks   = 0;
   int failures = 0;

`ifdef CMP2_OUT_REG_EN
   localparam bit REG_BUILD = 1'b1;
`else
   localparam bit REG_BUILD = 1'b0;
`endif

   logic [2:0] prev_exp;

   always #5 clk = ~clk;

   comparator_2bit_behavioral_design dut (
      .clk  (clk),
      .rst  (rst),
      .A0   (A0),
      .A1   (A1),
      .B0   (B0),
      .B1   (B1),
      .AgtB (AgtB),
      .AeqB (AeqB),
      .AltB (AltB)
   );

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain integer comparison of the two operand values.
   function automatic logic [2:0] ref_cmp(input int a, input int b);
      if (a > b)  return 3'b100;
      if (a == b) return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [2:0] flags();
      return {AgtB, AeqB, AltB};
   endfunction

   task automatic drive(input int a, input int b, input logic r);
      logic [1:0] av, bv;
      av  = 2'(a);
      bv  = 2'(b);
      A0  = av[0];
      A1  = av[1];
      B0  = bv[0];
      B1  = bv[1];
      rst = r;
   endtask

   // Drive on negedge; sample 2 ns later and again 1 ns after the following posedge.
   task automatic apply(input string tag, input int a, input int b, input logic r);
      logic [2:0] exp;
      @(negedge clk);
      drive(a, b, r);
      #2;
      if (REG_BUILD) begin
         check({tag, "_hold"}, flags(), prev_exp);
         exp = r ? 3'b010 : ref_cmp(a, b);
      end else begin
         exp = ref_cmp(a, b);
         check({tag, "_comb"}, flags(), exp);
      end
      @(posedge clk);
      #1;
      check(tag, flags(), exp);
      check({tag, "_onehot"}, 3'($countones(flags())), 3'd1);
      prev_exp = exp;
   endtask

   initial begin
      drive(0, 0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", flags(), 3'b010);
      prev_exp = 3'b010;

      apply("rst_release", 0, 0, 1'b0);

      for (int i = 0; i < 16; i++)
         apply($sformatf("sweep_a%0d_b%0d", i / 4, i % 4), i / 4, i % 4, 1'b0);

      apply("msb_dom_gt", 2, 1, 1'b0);
      apply("msb_dom_lt", 1, 2, 1'b0);
      apply("cap_3_0",    3, 0, 1'b0);
      apply("rst_a0_b3",  0, 3, 1'b1);
      apply("post_rst",   0, 3, 1'b0);
      apply("eq_hold_r1", 2, 2, 1'b1);
      apply("eq_hold_r0", 2, 2, 1'b0);
      apply("eq_hold_r2", 2, 2, 1'b1);
      apply("eq_hold_r3", 2, 2, 1'b0);

      for (int i = 0; i < 60; i++) begin
         int a, b;
         logic r;
         a = int'($urandom_range(3, 0));
         b = int'($urandom_range(3, 0));
         r = ($urandom_range(9, 0) == 0);
         apply($sformatf("rand%0d", i), a, b, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
